// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared types, constants and helpers for the PS/2 receive path.
//            - ps2_rx_state_t : receive FSM state encoding
//            - PS2_FRAME_BITS : start + 8 data + parity + stop
//            - odd_parity_ok  : odd-parity check over data byte + parity bit
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_rx_state_t;

    localparam int PS2_FRAME_BITS = 11;
    // Data bits in a frame: everything except start, parity and stop.
    localparam int PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

    // PS/2 uses odd parity: the nine bits together must hold an odd number
    // of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data_byte,
                                           input logic       parity_bit);
        return ^{data_byte, parity_bit};
    endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock first-word-fall-through FIFO. The head entry is
//            presented on rd_data_o while the FIFO is not empty; a read
//            simply advances the head. A write into a full FIFO is accepted
//            only when a read happens in the same cycle.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            wr_en_i/wr_data_i- write request and data
//            rd_en_i          - pop head (ignored when empty)
//            rd_data_o        - head entry, forced to 0 when empty
//            count_o          - number of stored entries
//            full_o, empty_o  - status
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8          // power of two, at least 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    logic w_do_rd;
    logic w_do_wr;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;

    assign w_do_rd = rd_en_i & ~empty_o;
    // When full, the slot freed by a simultaneous read makes room.
    assign w_do_wr = wr_en_i & (~full_o | w_do_rd);

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage is not reset: contents are only observable through rd_data_o,
    // which is masked while empty.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_fifo
// Purpose  : Host-side PS/2 receive front end. Synchronises and de-glitches
//            the raw PS/2 clock/data pads, deserialises 11-bit frames,
//            checks start/parity/stop and queues good bytes in a FWFT FIFO.
// Ports    : clk, rst              - system clock, sync active-high reset
//            ps2_clk, ps2_data     - raw asynchronous pad inputs
//            rd_en                 - pop head byte (ignored when empty)
//            rd_data, rd_valid     - head byte and FIFO-not-empty
//            count                 - FIFO occupancy
//            err_clr               - clears the sticky error flags
//            parity_err, frame_err, overflow - sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    input  logic                          err_clr,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    // ------------------------------------------------------------------
    // Input synchroniser (idle level of the bus is 1)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   w_clk_s;
    logic                   w_dat_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign w_clk_s = clk_sync_q[SYNC_STAGES-1];
    assign w_dat_s = dat_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Clock de-glitch filter: fclk follows the synced clock only once it
    // has disagreed with fclk for FILTER_LEN consecutive samples.
    // ------------------------------------------------------------------
    logic             fclk_q;
    logic             fclk_prev_q;
    logic [FLT_W-1:0] flt_cnt_q;
    logic             w_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            fclk_q      <= 1'b1;
            fclk_prev_q <= 1'b1;
            flt_cnt_q   <= '0;
        end else begin
            fclk_prev_q <= fclk_q;
            if (w_clk_s != fclk_q) begin
                if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                    fclk_q    <= w_clk_s;
                    flt_cnt_q <= '0;
                end else begin
                    flt_cnt_q <= flt_cnt_q + FLT_W'(1);
                end
            end else begin
                flt_cnt_q <= '0;
            end
        end
    end

    assign w_fall = fclk_prev_q & ~fclk_q;

    // ------------------------------------------------------------------
    // Frame receiver FSM
    // ------------------------------------------------------------------
    ps2_rx_state_t state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic          par_q;
    logic [TO_W-1:0] to_cnt_q;

    logic w_timeout;
    logic w_stop_fall;
    logic w_par_ok;
    logic w_push;
    logic w_set_pe;
    logic w_set_fe;
    logic w_set_ov;
    logic w_pop;
    logic w_full;
    logic w_empty;

    // The timeout fires on the cycle the idle count would reach
    // TIMEOUT_CYCLES; a fall in that same cycle keeps the frame alive.
    assign w_timeout = (state_q != IDLE) && !w_fall &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            if (state_q == IDLE || w_fall || w_timeout) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end

            case (state_q)
                IDLE: begin
                    // A fall with data high is not a start bit; ignore it.
                    if (w_fall && !w_dat_s) begin
                        bit_cnt_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (w_timeout) begin
                        state_q <= IDLE;
                    end else if (w_fall) begin
                        shift_q   <= {w_dat_s, shift_q[7:1]};   // LSB first
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) begin
                            state_q <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (w_timeout) begin
                        state_q <= IDLE;
                    end else if (w_fall) begin
                        par_q   <= w_dat_s;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (w_timeout || w_fall) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Frame verdict is decoded in the stop-bit fall cycle so the FIFO write
    // lands on the same clock edge.
    assign w_stop_fall = (state_q == STOP) && w_fall;
    assign w_par_ok    = odd_parity_ok(shift_q, par_q);
    assign w_push      = w_stop_fall &  w_dat_s &  w_par_ok;
    assign w_set_pe    = w_stop_fall &  w_dat_s & ~w_par_ok;
    // A bad stop bit outranks a parity failure.
    assign w_set_fe    = (w_stop_fall & ~w_dat_s) | w_timeout;
    assign w_pop       = rd_en & ~w_empty;
    assign w_set_ov    = w_push & w_full & ~w_pop;

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (w_push),
        .wr_data_i (shift_q),
        .rd_en_i   (rd_en),
        .rd_data_o (rd_data),
        .count_o   (count),
        .full_o    (w_full),
        .empty_o   (w_empty)
    );

    assign rd_valid = ~w_empty;

    // ------------------------------------------------------------------
    // Sticky error flags: a set event wins over a simultaneous clear.
    // ------------------------------------------------------------------
    logic parity_err_q;
    logic frame_err_q;
    logic overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            parity_err_q <= w_set_pe | (parity_err_q & ~err_clr);
            frame_err_q  <= w_set_fe | (frame_err_q  & ~err_clr);
            overflow_q   <= w_set_ov | (overflow_q   & ~err_clr);
        end
    end

    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule : ps2_rx_fifo
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx_fifo
// Purpose  : Self-checking bench for ps2_rx_fifo. Drives PS/2 frames bit by
//            bit, keeps a queue-based model of the byte FIFO and flags, and
//            compares every cycle, plus literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_fifo;

    localparam int S    = 2;
    localparam int F    = 4;
    localparam int D    = 8;
    localparam int TO   = 20000;
    // Raw pad edge -> S sync flops -> F filter samples -> FIFO write edge.
    localparam int LAT  = S + F + 1;
    localparam int HALF = 30;      // half of a 60-cycle bit period

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [$clog2(D):0] count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .SYNC_STAGES    (S),
        .FILTER_LEN     (F),
        .FIFO_DEPTH     (D),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .count      (count),
        .err_clr    (err_clr),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    // Behavioural model
    logic [7:0] mq[$];
    bit         mpe, mfe, mov;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Continuous comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
            chk("rd_data", 32'(rd_data), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
            chk("count", 32'(count), 32'(mq.size()));
            chk("parity_err", 32'(parity_err), 32'(mpe));
            chk("frame_err", 32'(frame_err), 32'(mfe));
            chk("overflow", 32'(overflow), 32'(mov));
        end
    end

    // Outcome of a complete frame at its push edge.
    task automatic model_frame(input logic [7:0] b, input logic par,
                               input logic stp, input bit pop, input bit clr);
        bit push;
        bit full;
        push = 1'b0;
        full = (mq.size() == D);
        if (clr) begin
            mpe = 1'b0; mfe = 1'b0; mov = 1'b0;
        end
        if (!stp)                 mfe  = 1'b1;
        else if ((^b ^ par) != 1) mpe  = 1'b1;
        else                      push = 1'b1;
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (push) begin
            if (full && !pop) mov = 1'b1;
            else              mq.push_back(b);
        end
    endtask

    // nbits < 11 sends a truncated frame; glitch_bit selects a bit whose
    // high phase carries a (F-1)-cycle low glitch.
    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop, input bit pop_at_push,
                              input bit clr_at_push, input int glitch_bit,
                              input int nbits);
        logic [10:0] fr;
        fr[0]   = 1'b0;
        fr[8:1] = b;
        fr[9]   = ~(^b) ^ bad_par;
        fr[10]  = ~bad_stop;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) ps2_data = fr[i];
            if (glitch_bit == i) begin
                repeat (5) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (F - 1) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (HALF - 1 - 5 - (F - 1)) @(negedge clk);
            end else begin
                repeat (HALF - 1) @(negedge clk);
            end
            ps2_clk = 1'b0;
            if (i == 10) begin
                if (pop_at_push || clr_at_push) begin
                    repeat (LAT - 1) @(posedge clk);
                    @(negedge clk);
                    rd_en   = pop_at_push;
                    err_clr = clr_at_push;
                    @(posedge clk);
                    model_frame(b, fr[9], fr[10], pop_at_push, clr_at_push);
                    @(negedge clk);
                    rd_en   = 1'b0;
                    err_clr = 1'b0;
                    repeat (HALF - LAT - 1) @(negedge clk);
                end else begin
                    repeat (LAT) @(posedge clk);
                    model_frame(b, fr[9], fr[10], 1'b0, 1'b0);
                    repeat (HALF - LAT) @(negedge clk);
                end
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 1'b0, 1'b0, -1, 11);
    endtask

    task automatic pop();
        @(negedge clk) rd_en = 1'b1;
        @(posedge clk);
        if (mq.size() > 0) void'(mq.pop_front());
        @(negedge clk) rd_en = 1'b0;
    endtask

    task automatic clr();
        @(negedge clk) err_clr = 1'b1;
        @(posedge clk);
        mpe = 1'b0; mfe = 1'b0; mov = 1'b0;
        @(negedge clk) err_clr = 1'b0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        mq.delete();
        mpe = 1'b0; mfe = 1'b0; mov = 1'b0;
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    initial begin
        #(900_000 * 10);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] rb;
    int         rr;

    initial begin
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        rd_en = 1'b0; err_clr = 1'b0;
        mpe = 1'b0; mfe = 1'b0; mov = 1'b0;
        do_reset();
        @(negedge clk);
        chk("reset valid", 32'(rd_valid), 0);
        chk("reset data", 32'(rd_data), 0);
        chk("reset count", 32'(count), 0);
        chk("reset flags", 32'({parity_err, frame_err, overflow}), 0);

        // Basic 0x1C frame
        good(8'h1C);
        chk("0x1C data", 32'(rd_data), 32'h1C);
        chk("0x1C count", 32'(count), 1);
        chk("0x1C flags", 32'({parity_err, frame_err, overflow}), 0);
        pop();
        chk("0x1C popped", 32'(count), 0);

        // Parity error, then a good frame with the flag still sticky
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, -1, 11);
        chk("par err flag", 32'(parity_err), 1);
        chk("par err empty", 32'(count), 0);
        good(8'hF0);
        chk("0xF0 data", 32'(rd_data), 32'hF0);
        chk("par err sticky", 32'(parity_err), 1);
        pop();
        clr();
        chk("par err cleared", 32'(parity_err), 0);

        // Bad stop bit (also with bad parity: frame error takes priority)
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, -1, 11);
        chk("stop err flag", 32'(frame_err), 1);
        chk("stop err no par", 32'(parity_err), 0);
        chk("stop err empty", 32'(rd_valid), 0);
        clr();

        // Set wins over a simultaneous clear
        send_frame(8'h42, 1'b1, 1'b0, 1'b0, 1'b1, -1, 11);
        chk("set beats clear", 32'(parity_err), 1);
        clr();

        // Timeout: 5 data bits then the clock stays high
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, -1, 6);
        repeat (TO - 100) @(negedge clk);
        chk("no early timeout", 32'(frame_err), 0);
        chk_en = 1'b0;
        repeat (150) @(negedge clk);
        mfe = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("timeout flag", 32'(frame_err), 1);
        good(8'h55);
        chk("after timeout", 32'(rd_data), 32'h55);
        pop();
        clr();

        // Overflow: nine frames, no reads
        for (int i = 1; i <= 9; i++) good(8'(i));
        chk("ovf count", 32'(count), 8);
        chk("ovf flag", 32'(overflow), 1);
        for (int i = 1; i <= 8; i++) begin
            chk("ovf order", 32'(rd_data), 32'(i));
            pop();
        end
        clr();

        // Full FIFO with pop on the push edge
        for (int i = 1; i <= 8; i++) good(8'(i));
        send_frame(8'h09, 1'b0, 1'b0, 1'b1, 1'b0, -1, 11);
        chk("pp count", 32'(count), 8);
        chk("pp overflow", 32'(overflow), 0);
        chk("pp head", 32'(rd_data), 32'h02);
        for (int i = 2; i <= 9; i++) begin
            chk("pp order", 32'(rd_data), 32'(i));
            pop();
        end

        // Glitches in IDLE and mid-frame are filtered out
        send_frame(8'h3A, 1'b0, 1'b0, 1'b0, 1'b0, 0, 11);
        chk("glitch idle", 32'(rd_data), 32'h3A);
        pop();
        send_frame(8'hC6, 1'b0, 1'b0, 1'b0, 1'b0, 4, 11);
        chk("glitch mid", 32'(rd_data), 32'hC6);
        chk("glitch count", 32'(count), 1);

        // Reset mid-frame with content and a flag present
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, -1, 11);
        send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b0, -1, 6);
        do_reset();
        @(negedge clk);
        chk("rst count", 32'(count), 0);
        chk("rst flags", 32'({parity_err, frame_err, overflow}), 0);
        good(8'hA5);
        chk("post rst", 32'(rd_data), 32'hA5);
        pop();
        pop();   // pop on empty is ignored

        // Randomised traffic
        for (int k = 0; k < 25; k++) begin
            rb = 8'($urandom);
            rr = $urandom_range(0, 99);
            send_frame(rb, rr < 15, (rr >= 15 && rr < 25),
                       $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                       -1, 11);
            repeat ($urandom_range(0, 2)) pop();
            if ($urandom_range(0, 3) == 0) clr();
        end

        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ps2_rx_fifo
`default_nettype wire

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Host-side PS/2 receive front end for the keyboard and mouse inputs of wiggly_ic_1.
- Synchronises and de-glitches the raw ps2_clk/ps2_data pad inputs, deserialises 11-bit device-to-host frames and checks start, parity and stop bits.
- Queues good bytes in a small first-word-fall-through FIFO for the downstream scancode/packet decoder.
- One instance per PS/2 port; both instances run in the wb_clk_i domain.

Parameters:
- SYNC_STAGES, 2, flops in the input synchroniser on ps2_clk and ps2_data (minimum 2).
- FILTER_LEN, 4, consecutive equal synced samples required before filtered ps2_clk changes value.
- FIFO_DEPTH, 8, byte entries; must be a power of two, at least 2.
- TIMEOUT_CYCLES, 20000, idle clk cycles allowed between falling edges inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock (wb_clk_i).
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pad input, asynchronous.
- ps2_data  in  1  raw PS/2 data pad input, asynchronous.
- rd_en  in  1  pop the head byte; ignored when rd_valid=0.
- rd_data  out  8  head byte of the FIFO; valid only while rd_valid=1.
- rd_valid  out  1  FIFO not empty.
- count  out  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.
- err_clr  in  1  clears all sticky error flags.
- parity_err  out  1  sticky; set by a frame that fails odd parity.
- frame_err  out  1  sticky; set by a bad stop bit or a timeout.
- overflow  out  1  sticky; set when a good byte is dropped because the FIFO is full.

Behaviour:
- Reset, synchronous and active-high:
  - All outputs go to 0; FIFO becomes empty.
  - FSM goes to IDLE.
  - Synchroniser and filter flops load 1, the PS/2 idle level.
  - A reset mid-frame discards the partial frame; no flag is set.
- Input conditioning:
  - ps2_clk and ps2_data each pass through SYNC_STAGES flops.
  - Filtered clock fclk takes the synced ps2_clk value only after FILTER_LEN consecutive equal samples.
  - fall = fclk 1->0 transition, a one-cycle pulse.
  - Data is sampled as the synced ps2_data value in the fall cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 (start bit), clear the bit counter and go to DATA. On fall with data=1, stay in IDLE with no flag.
  - DATA: on each fall, shift the bit in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: on fall, store the parity bit and go to STOP.
  - STOP: on fall, always go to IDLE.
    - Stop bit = 1 and parity OK (XOR of the 8 data bits and the parity bit equals 1): push the byte.
    - Stop bit = 1 and parity bad: set parity_err; no push.
    - Stop bit = 0: set frame_err; no push. This takes priority over a parity check.
- Timeout:
  - A counter resets on every fall and counts in DATA, PARITY and STOP.
  - Reaching TIMEOUT_CYCLES sets frame_err and returns the FSM to IDLE; no push.
- Latency: the stop-bit fall is detected in cycle N; the push registers at the end of N, so rd_valid and rd_data are valid in cycle N+1.
- FIFO:
  - rd_data is driven from the head entry (first-word fall-through).
  - A pop takes effect at the clock edge where rd_en=1 and rd_valid=1.
  - Push while full with no pop: drop the byte and set overflow; contents unchanged.
  - Push and pop in the same cycle while full: both succeed; count stays FIFO_DEPTH; overflow is not set.
  - Push and pop in the same cycle at other levels: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags:
  - err_clr=1 clears all three flags.
  - If a set event and err_clr occur in the same cycle, set wins.
- ps2_clk and ps2_data are never driven by this block (receive only).

Decomposition:
- Shared package ps2_pkg holds:
  - enum ps2_rx_state_t {IDLE, DATA, PARITY, STOP};
  - constant PS2_FRAME_BITS = 11;
  - function odd_parity_ok(byte, bit).
- One natural sub-module: sync_fifo (parameters WIDTH, DEPTH), providing first-word fall-through, count, full and empty. The wiggly_ic_1 mouse path reuses it.

Test Plan:
- Frame for 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at a 60 us bit period → rd_valid=1 and rd_data=0x1C one cycle after the stop-bit fall; count=1; no flags set.
- Frame for 0x1C with parity bit 1 → no push; parity_err=1. Next frame 0xF0 (parity 1) → pushed normally; parity_err stays 1 until err_clr is pulsed.
- Frame with stop bit 0 → frame_err=1, FIFO empty. Separately, abort after 5 data bits and hold ps2_clk high for TIMEOUT_CYCLES → frame_err=1, FSM back in IDLE; the next full frame 0x55 is received correctly.
- 9 back-to-back good frames 0x01..0x09 with rd_en=0 → count=8, overflow=1; pops return 0x01..0x08 in order.
- FIFO full, then the 9th stop-bit push cycle coincides with rd_en=1 → 0x01 popped, 0x09 accepted, count stays 8, overflow=0.
- ps2_clk glitches low for FILTER_LEN-1 cycles while in IDLE and mid-frame → no fall detected; bit count and data unaffected; assert rst mid-frame → all outputs 0, and the next frame is received cleanly.
